// File: rtl/rs_alu.sv
// ALU reservation station: buffers dispatched integer ops, snoops the ALU and LSB result
// buses for missing operands, and issues the lowest-index ready entry to the ALU each cycle.
module rs_alu #(
  parameter int unsigned RS_SIZE   = 8,
  parameter int unsigned ROB_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback_config,
  input  logic                 in_config,
  input  logic [6:0]           in_opcode,
  input  logic [2:0]           in_precise,
  input  logic [31:0]          in_imm,
  input  logic [31:0]          in_PC,
  input  logic [ROB_WIDTH-1:0] in_rob_entry,
  input  logic                 in_Qj_busy,
  input  logic [ROB_WIDTH-1:0] in_Qj,
  input  logic [31:0]          in_Vj,
  input  logic                 in_Qk_busy,
  input  logic [ROB_WIDTH-1:0] in_Qk,
  input  logic [31:0]          in_Vk,
  input  logic                 alu_config,
  input  logic [ROB_WIDTH-1:0] alu_rob_entry,
  input  logic [31:0]          alu_val,
  input  logic                 lsb_config,
  input  logic [ROB_WIDTH-1:0] lsb_rob_entry,
  input  logic [31:0]          lsb_val,
  output logic                 out_full,
  output logic                 out_config,
  output logic [31:0]          out_a,
  output logic [31:0]          out_b,
  output logic [31:0]          out_PC,
  output logic [6:0]           out_opcode,
  output logic [2:0]           out_precise,
  output logic [31:0]          out_imm,
  output logic [ROB_WIDTH-1:0] out_rob_entry
);

  localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic                 busy_q    [RS_SIZE];
  logic                 busy_d    [RS_SIZE];
  logic [6:0]           opcode_q  [RS_SIZE];
  logic [6:0]           opcode_d  [RS_SIZE];
  logic [2:0]           precise_q [RS_SIZE];
  logic [2:0]           precise_d [RS_SIZE];
  logic [31:0]          imm_q     [RS_SIZE];
  logic [31:0]          imm_d     [RS_SIZE];
  logic [31:0]          pc_q      [RS_SIZE];
  logic [31:0]          pc_d      [RS_SIZE];
  logic [ROB_WIDTH-1:0] rob_q     [RS_SIZE];
  logic [ROB_WIDTH-1:0] rob_d     [RS_SIZE];
  logic                 qj_busy_q [RS_SIZE];
  logic                 qj_busy_d [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj_q      [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj_d      [RS_SIZE];
  logic [31:0]          vj_q      [RS_SIZE];
  logic [31:0]          vj_d      [RS_SIZE];
  logic                 qk_busy_q [RS_SIZE];
  logic                 qk_busy_d [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk_q      [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk_d      [RS_SIZE];
  logic [31:0]          vk_q      [RS_SIZE];
  logic [31:0]          vk_d      [RS_SIZE];

  logic                 out_config_q, out_config_d;
  logic [31:0]          out_a_q, out_a_d;
  logic [31:0]          out_b_q, out_b_d;
  logic [31:0]          out_pc_q, out_pc_d;
  logic [6:0]           out_opcode_q, out_opcode_d;
  logic [2:0]           out_precise_q, out_precise_d;
  logic [31:0]          out_imm_q, out_imm_d;
  logic [ROB_WIDTH-1:0] out_rob_q, out_rob_d;

  logic            full;
  logic [IdxW-1:0] free_idx;
  logic            iss_valid;
  logic [IdxW-1:0] iss_idx;

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    full      = 1'b1;
    free_idx  = '0;
    iss_valid = 1'b0;
    iss_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        full     = 1'b0;
        free_idx = IdxW'(i);
      end
      if (busy_q[i] && !qj_busy_q[i] && !qk_busy_q[i]) begin
        iss_valid = 1'b1;
        iss_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    busy_d        = busy_q;
    opcode_d      = opcode_q;
    precise_d     = precise_q;
    imm_d         = imm_q;
    pc_d          = pc_q;
    rob_d         = rob_q;
    qj_busy_d     = qj_busy_q;
    qj_d          = qj_q;
    vj_d          = vj_q;
    qk_busy_d     = qk_busy_q;
    qk_d          = qk_q;
    vk_d          = vk_q;
    out_config_d  = out_config_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_pc_d      = out_pc_q;
    out_opcode_d  = out_opcode_q;
    out_precise_d = out_precise_q;
    out_imm_d     = out_imm_q;
    out_rob_d     = out_rob_q;

    if (rdy) begin
      if (rollback_config) begin
        for (int i = 0; i < RS_SIZE; i++) busy_d[i] = 1'b0;
        out_config_d = 1'b0;
      end else begin
        // Wakeup: the ALU bus takes priority when both buses carry the same tag.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && qj_busy_q[i]) begin
            if (alu_config && alu_rob_entry == qj_q[i]) begin
              vj_d[i]      = alu_val;
              qj_busy_d[i] = 1'b0;
            end else if (lsb_config && lsb_rob_entry == qj_q[i]) begin
              vj_d[i]      = lsb_val;
              qj_busy_d[i] = 1'b0;
            end
          end
          if (busy_q[i] && qk_busy_q[i]) begin
            if (alu_config && alu_rob_entry == qk_q[i]) begin
              vk_d[i]      = alu_val;
              qk_busy_d[i] = 1'b0;
            end else if (lsb_config && lsb_rob_entry == qk_q[i]) begin
              vk_d[i]      = lsb_val;
              qk_busy_d[i] = 1'b0;
            end
          end
        end

        out_config_d = iss_valid;
        if (iss_valid) begin
          out_a_d         = vj_q[iss_idx];
          out_b_d         = vk_q[iss_idx];
          out_pc_d        = pc_q[iss_idx];
          out_opcode_d    = opcode_q[iss_idx];
          out_precise_d   = precise_q[iss_idx];
          out_imm_d       = imm_q[iss_idx];
          out_rob_d       = rob_q[iss_idx];
          busy_d[iss_idx] = 1'b0;
        end

        // free_idx is never the issuing slot, so both may happen in one cycle.
        if (in_config && !full) begin
          busy_d[free_idx]    = 1'b1;
          opcode_d[free_idx]  = in_opcode;
          precise_d[free_idx] = in_precise;
          imm_d[free_idx]     = in_imm;
          pc_d[free_idx]      = in_PC;
          rob_d[free_idx]     = in_rob_entry;
          qj_busy_d[free_idx] = in_Qj_busy;
          qj_d[free_idx]      = in_Qj;
          vj_d[free_idx]      = in_Vj;
          qk_busy_d[free_idx] = in_Qk_busy;
          qk_d[free_idx]      = in_Qk;
          vk_d[free_idx]      = in_Vk;
          if (in_Qj_busy && alu_config && alu_rob_entry == in_Qj) begin
            vj_d[free_idx]      = alu_val;
            qj_busy_d[free_idx] = 1'b0;
          end else if (in_Qj_busy && lsb_config && lsb_rob_entry == in_Qj) begin
            vj_d[free_idx]      = lsb_val;
            qj_busy_d[free_idx] = 1'b0;
          end
          if (in_Qk_busy && alu_config && alu_rob_entry == in_Qk) begin
            vk_d[free_idx]      = alu_val;
            qk_busy_d[free_idx] = 1'b0;
          end else if (in_Qk_busy && lsb_config && lsb_rob_entry == in_Qk) begin
            vk_d[free_idx]      = lsb_val;
            qk_busy_d[free_idx] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        busy_q[i]    <= 1'b0;
        opcode_q[i]  <= '0;
        precise_q[i] <= '0;
        imm_q[i]     <= '0;
        pc_q[i]      <= '0;
        rob_q[i]     <= '0;
        qj_busy_q[i] <= 1'b0;
        qj_q[i]      <= '0;
        vj_q[i]      <= '0;
        qk_busy_q[i] <= 1'b0;
        qk_q[i]      <= '0;
        vk_q[i]      <= '0;
      end
      out_config_q  <= 1'b0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_pc_q      <= '0;
      out_opcode_q  <= '0;
      out_precise_q <= '0;
      out_imm_q     <= '0;
      out_rob_q     <= '0;
    end else begin
      busy_q        <= busy_d;
      opcode_q      <= opcode_d;
      precise_q     <= precise_d;
      imm_q         <= imm_d;
      pc_q          <= pc_d;
      rob_q         <= rob_d;
      qj_busy_q     <= qj_busy_d;
      qj_q          <= qj_d;
      vj_q          <= vj_d;
      qk_busy_q     <= qk_busy_d;
      qk_q          <= qk_d;
      vk_q          <= vk_d;
      out_config_q  <= out_config_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_pc_q      <= out_pc_d;
      out_opcode_q  <= out_opcode_d;
      out_precise_q <= out_precise_d;
      out_imm_q     <= out_imm_d;
      out_rob_q     <= out_rob_d;
    end
  end

  assign out_full      = full;
  assign out_config    = out_config_q;
  assign out_a         = out_a_q;
  assign out_b         = out_b_q;
  assign out_PC        = out_pc_q;
  assign out_opcode    = out_opcode_q;
  assign out_precise   = out_precise_q;
  assign out_imm       = out_imm_q;
  assign out_rob_entry = out_rob_q;

endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: directed scenarios plus randomized traffic checked against an
// entry-table reference model kept in the bench.
module tb_rs_alu;
  localparam int RS = 8;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, rollback_config, in_config;
  logic [6:0]    in_opcode;
  logic [2:0]    in_precise;
  logic [31:0]   in_imm, in_PC, in_Vj, in_Vk, alu_val, lsb_val;
  logic [RW-1:0] in_rob_entry, in_Qj, in_Qk, alu_rob_entry, lsb_rob_entry;
  logic          in_Qj_busy, in_Qk_busy, alu_config, lsb_config;
  logic          out_full, out_config;
  logic [31:0]   out_a, out_b, out_PC, out_imm;
  logic [6:0]    out_opcode;
  logic [2:0]    out_precise;
  logic [RW-1:0] out_rob_entry;

  always #5 clk = ~clk;

  rs_alu #(.RS_SIZE(RS), .ROB_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_config(rollback_config),
    .in_config(in_config), .in_opcode(in_opcode), .in_precise(in_precise),
    .in_imm(in_imm), .in_PC(in_PC), .in_rob_entry(in_rob_entry),
    .in_Qj_busy(in_Qj_busy), .in_Qj(in_Qj), .in_Vj(in_Vj),
    .in_Qk_busy(in_Qk_busy), .in_Qk(in_Qk), .in_Vk(in_Vk),
    .alu_config(alu_config), .alu_rob_entry(alu_rob_entry), .alu_val(alu_val),
    .lsb_config(lsb_config), .lsb_rob_entry(lsb_rob_entry), .lsb_val(lsb_val),
    .out_full(out_full), .out_config(out_config), .out_a(out_a), .out_b(out_b),
    .out_PC(out_PC), .out_opcode(out_opcode), .out_precise(out_precise),
    .out_imm(out_imm), .out_rob_entry(out_rob_entry)
  );

  typedef struct {
    bit        busy;
    bit [6:0]  op;
    bit [2:0]  f3;
    bit [31:0] imm, pc;
    bit [3:0]  rob;
    bit        jb;
    bit [3:0]  qj;
    bit [31:0] vj;
    bit        kb;
    bit [3:0]  qk;
    bit [31:0] vk;
  } ent_t;

  ent_t       m_ent[RS];
  bit         m_cfg;
  bit [141:0] m_pay;
  int         n_checks = 0;
  int         n_errors = 0;
  int         viol = 0;

  always @(posedge clk)
    if (rst && rdy && in_config && out_full) begin
      viol++;
      $display("note: dispatch attempted while full at %0t", $time);
    end

  function automatic void model_reset();
    for (int i = 0; i < RS; i++) m_ent[i].busy = 0;
    m_cfg = 0;
    m_pay = '0;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < RS; i++) if (m_ent[i].busy) n++;
    return n;
  endfunction

  function automatic bit snoop(input bit [3:0] tag, output bit [31:0] v);
    v = 0;
    if (alu_config && alu_rob_entry == tag) begin v = alu_val; return 1; end
    if (lsb_config && lsb_rob_entry == tag) begin v = lsb_val; return 1; end
    return 0;
  endfunction

  function automatic void model_step();
    ent_t      old[RS];
    bit [31:0] v;
    int        pick;
    bit        was_full;
    if (!rst) begin model_reset(); return; end
    if (!rdy) return;
    if (rollback_config) begin
      for (int i = 0; i < RS; i++) m_ent[i].busy = 0;
      m_cfg = 0;
      return;
    end
    old      = m_ent;
    was_full = (model_count() == RS);
    for (int i = 0; i < RS; i++) if (old[i].busy) begin
      if (old[i].jb && snoop(old[i].qj, v)) begin m_ent[i].jb = 0; m_ent[i].vj = v; end
      if (old[i].kb && snoop(old[i].qk, v)) begin m_ent[i].kb = 0; m_ent[i].vk = v; end
    end
    pick = -1;
    for (int i = 0; i < RS; i++)
      if (pick < 0 && old[i].busy && !old[i].jb && !old[i].kb) pick = i;
    m_cfg = (pick >= 0);
    if (pick >= 0) begin
      m_pay = {old[pick].vj, old[pick].vk, old[pick].pc, old[pick].imm,
               old[pick].op, old[pick].f3, old[pick].rob};
      m_ent[pick].busy = 0;
    end
    if (in_config && !was_full) begin
      pick = -1;
      for (int i = 0; i < RS; i++) if (pick < 0 && !old[i].busy) pick = i;
      m_ent[pick].busy = 1;
      m_ent[pick].op = in_opcode;  m_ent[pick].f3 = in_precise;
      m_ent[pick].imm = in_imm;    m_ent[pick].pc = in_PC;
      m_ent[pick].rob = in_rob_entry;
      m_ent[pick].jb = in_Qj_busy; m_ent[pick].qj = in_Qj; m_ent[pick].vj = in_Vj;
      m_ent[pick].kb = in_Qk_busy; m_ent[pick].qk = in_Qk; m_ent[pick].vk = in_Vk;
      if (in_Qj_busy && snoop(in_Qj, v)) begin m_ent[pick].jb = 0; m_ent[pick].vj = v; end
      if (in_Qk_busy && snoop(in_Qk, v)) begin m_ent[pick].kb = 0; m_ent[pick].vk = v; end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1; rollback_config = 0; in_config = 0; alu_config = 0; lsb_config = 0;
  endtask

  task automatic disp(input bit [3:0] rob, input bit jb, input bit [3:0] qj,
                      input bit [31:0] vj, input bit kb, input bit [3:0] qk,
                      input bit [31:0] vk, input bit [31:0] imm);
    in_config = 1; in_opcode = (jb || kb) ? 7'h33 : 7'h13; in_precise = rob[2:0];
    in_imm = imm; in_PC = 32'h1000 + 32'(rob) * 4; in_rob_entry = rob;
    in_Qj_busy = jb; in_Qj = qj; in_Vj = vj; in_Qk_busy = kb; in_Qk = qk; in_Vk = vk;
  endtask

  task automatic test_reset();
    idle();
    in_opcode = 0; in_precise = 0; in_imm = 0; in_PC = 0; in_rob_entry = 0;
    in_Qj_busy = 0; in_Qj = 0; in_Vj = 0; in_Qk_busy = 0; in_Qk = 0; in_Vk = 0;
    alu_rob_entry = 0; alu_val = 0; lsb_rob_entry = 0; lsb_val = 0;
    rst = 0;
    model_reset();
    #1;
    n_checks++;
    if ({out_config, out_full, out_a, out_b, out_PC, out_imm, out_opcode, out_precise,
         out_rob_entry} !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got cfg=%0b full=%0b a=%h rob=%0d want all 0",
                           out_config, out_full, out_a, out_rob_entry);
    end
    tick();
    rst = 1;
  endtask

  task automatic test_ready_dispatch();
    disp(4'd2, 0, 0, 32'd5, 0, 0, 32'd0, 32'd3);
    tick(); idle();
    n_checks++;
    if (out_config !== 1'b0) begin
      n_errors++; $display("FAIL t1_early: out_config=%0b want 0", out_config);
    end
    tick();
    n_checks++;
    if (out_config !== 1'b1 || out_a !== 32'd5 || out_imm !== 32'd3 || out_rob_entry !== 4'd2)
    begin
      n_errors++; $display("FAIL t1_issue: cfg=%0b a=%0d imm=%0d rob=%0d want 1 5 3 2",
                           out_config, out_a, out_imm, out_rob_entry);
    end
    tick();
    n_checks++;
    if (out_config !== 1'b0) begin
      n_errors++; $display("FAIL t1_pulse: out_config=%0b want 0", out_config);
    end
  endtask

  task automatic test_wakeup();
    disp(4'd3, 1, 4'd4, 32'd0, 0, 0, 32'd7, 32'd0);
    tick(); idle(); tick();
    alu_config = 1; alu_rob_entry = 4'd4; alu_val = 32'd10;
    tick(); idle();
    n_checks++;
    if (out_config !== 1'b0) begin
      n_errors++; $display("FAIL t2_early: out_config=%0b want 0", out_config);
    end
    tick();
    n_checks++;
    if (out_config !== 1'b1 || out_a !== 32'd10 || out_b !== 32'd7 || out_rob_entry !== 4'd3)
    begin
      n_errors++; $display("FAIL t2_issue: cfg=%0b a=%0d b=%0d rob=%0d want 1 10 7 3",
                           out_config, out_a, out_b, out_rob_entry);
    end
    tick();
  endtask

  task automatic test_bypass();
    disp(4'd4, 0, 0, 32'd1, 1, 4'd6, 32'd0, 32'd0);
    lsb_config = 1; lsb_rob_entry = 4'd6; lsb_val = 32'hDEAD;
    tick(); idle(); tick();
    n_checks++;
    if (out_config !== 1'b1 || out_b !== 32'hDEAD || out_rob_entry !== 4'd4) begin
      n_errors++; $display("FAIL t3_bypass: cfg=%0b b=%h rob=%0d want 1 dead 4",
                           out_config, out_b, out_rob_entry);
    end
    tick();
  endtask

  task automatic test_full();
    int v0;
    for (int i = 0; i < RS; i++) begin
      disp(4'(i), 1, 4'(8 + i), 32'd0, 0, 0, 32'(i), 32'(i));
      tick();
    end
    idle();
    n_checks++;
    if (out_full !== 1'b1) begin
      n_errors++; $display("FAIL t4_full: out_full=%0b want 1", out_full);
    end
    v0 = viol;
    disp(4'd15, 0, 0, 32'hBAD, 0, 0, 32'hBAD, 32'd0);
    tick(); idle();
    n_checks++;
    if (viol !== v0 + 1) begin
      n_errors++; $display("FAIL t4_flag: violations=%0d want %0d", viol, v0 + 1);
    end
    tick();
    n_checks++;
    if (out_config !== 1'b0 || out_full !== 1'b1) begin
      n_errors++; $display("FAIL t4_drop: cfg=%0b full=%0b want 0 1", out_config, out_full);
    end
    alu_config = 1; alu_rob_entry = 4'd11; alu_val = 32'h33;
    tick(); idle(); tick();
    n_checks++;
    if (out_config !== 1'b1 || out_rob_entry !== 4'd3 || out_a !== 32'h33 || out_full !== 1'b0)
    begin
      n_errors++; $display("FAIL t4_wake3: cfg=%0b rob=%0d a=%h full=%0b want 1 3 33 0",
                           out_config, out_rob_entry, out_a, out_full);
    end
    disp(4'd13, 1, 4'd5, 32'd0, 0, 0, 32'd0, 32'd0);
    tick(); idle();
    alu_config = 1; alu_rob_entry = 4'd5; alu_val = 32'h55;
    lsb_config = 1; lsb_rob_entry = 4'd12; lsb_val = 32'h44;
    tick(); idle(); tick();
    n_checks++;
    if (out_config !== 1'b1 || out_rob_entry !== 4'd13 || out_a !== 32'h55) begin
      n_errors++; $display("FAIL t4_slot3: cfg=%0b rob=%0d a=%h want 1 13 55",
                           out_config, out_rob_entry, out_a);
    end
    tick();
    n_checks++;
    if (out_config !== 1'b1 || out_rob_entry !== 4'd4 || out_a !== 32'h44) begin
      n_errors++; $display("FAIL t4_slot4: cfg=%0b rob=%0d a=%h want 1 4 44",
                           out_config, out_rob_entry, out_a);
    end
    rollback_config = 1;
    tick(); idle();
    n_checks++;
    if (out_full !== 1'b0 || out_config !== 1'b0) begin
      n_errors++; $display("FAIL t4_flush: full=%0b cfg=%0b want 0 0", out_full, out_config);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 6; i++) begin
      disp(4'(i), 1, 4'(i), 32'd0, 0, 0, 32'd0, 32'd0);
      tick();
    end
    idle();
    alu_config = 1; alu_rob_entry = 4'd1; alu_val = 32'h11;
    lsb_config = 1; lsb_rob_entry = 4'd5; lsb_val = 32'h55;
    tick(); idle(); tick();
    n_checks++;
    if (out_config !== 1'b1 || out_rob_entry !== 4'd1 || out_a !== 32'h11) begin
      n_errors++; $display("FAIL t5_first: cfg=%0b rob=%0d a=%h want 1 1 11",
                           out_config, out_rob_entry, out_a);
    end
    tick();
    n_checks++;
    if (out_config !== 1'b1 || out_rob_entry !== 4'd5 || out_a !== 32'h55) begin
      n_errors++; $display("FAIL t5_second: cfg=%0b rob=%0d a=%h want 1 5 55",
                           out_config, out_rob_entry, out_a);
    end
    tick();
  endtask

  task automatic test_rollback_freeze();
    disp(4'd9, 0, 0, 32'd9, 0, 0, 32'd9, 32'd0);
    rollback_config = 1;
    alu_config = 1; alu_rob_entry = 4'd0; alu_val = 32'd1;
    tick(); idle();
    n_checks++;
    if (out_config !== 1'b0) begin
      n_errors++; $display("FAIL t6_rb_pulse: out_config=%0b want 0", out_config);
    end
    alu_config = 1; alu_rob_entry = 4'd2; alu_val = 32'd2;
    lsb_config = 1; lsb_rob_entry = 4'd3; lsb_val = 32'd3;
    tick(); idle(); tick();
    n_checks++;
    if (out_config !== 1'b0 || out_full !== 1'b0) begin
      n_errors++; $display("FAIL t6_rb_empty: cfg=%0b full=%0b want 0 0", out_config, out_full);
    end
    disp(4'd7, 0, 0, 32'h70, 0, 0, 32'd0, 32'd0); tick();
    disp(4'd8, 0, 0, 32'h80, 0, 0, 32'd0, 32'd0); tick();
    disp(4'd9, 0, 0, 32'h90, 0, 0, 32'd0, 32'd0); tick();
    disp(4'd10, 0, 0, 32'hA0, 0, 0, 32'd0, 32'd0);
    rdy = 0; rollback_config = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (out_config !== 1'b1 || out_rob_entry !== 4'd8 || out_a !== 32'h80) begin
        n_errors++; $display("FAIL t6_freeze%0d: cfg=%0b rob=%0d a=%h want 1 8 80",
                             c, out_config, out_rob_entry, out_a);
      end
    end
    idle(); tick();
    n_checks++;
    if (out_config !== 1'b1 || out_rob_entry !== 4'd9 || out_a !== 32'h90) begin
      n_errors++; $display("FAIL t6_resume: cfg=%0b rob=%0d a=%h want 1 9 90",
                           out_config, out_rob_entry, out_a);
    end
    tick();
    n_checks++;
    if (out_config !== 1'b0) begin
      n_errors++; $display("FAIL t6_drained: out_config=%0b want 0", out_config);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rdy = ($urandom_range(0, 7) != 0);
      rollback_config = ($urandom_range(0, 39) == 0);
      in_config = $urandom_range(0, 1);
      in_opcode = 7'($urandom); in_precise = 3'($urandom);
      in_imm = $urandom; in_PC = $urandom; in_rob_entry = 4'($urandom);
      in_Qj_busy = $urandom_range(0, 1); in_Qj = 4'($urandom_range(0, 3)); in_Vj = $urandom;
      in_Qk_busy = $urandom_range(0, 1); in_Qk = 4'($urandom_range(0, 3)); in_Vk = $urandom;
      alu_config = ($urandom_range(0, 2) == 0);
      alu_rob_entry = 4'($urandom_range(0, 3)); alu_val = $urandom;
      lsb_config = ($urandom_range(0, 2) == 0);
      lsb_rob_entry = 4'($urandom_range(0, 3)); lsb_val = $urandom;
      tick();
      n_checks++;
      if (out_config !== m_cfg || out_full !== (model_count() == RS)) begin
        n_errors++; $display("FAIL rnd_ctl cyc %0d: cfg=%0b full=%0b want %0b %0b", c,
                             out_config, out_full, m_cfg, model_count() == RS);
      end
      n_checks++;
      if ({out_a, out_b, out_PC, out_imm, out_opcode, out_precise, out_rob_entry} !== m_pay)
      begin
        n_errors++; $display("FAIL rnd_pay cyc %0d: got %h want %h", c,
          {out_a, out_b, out_PC, out_imm, out_opcode, out_precise, out_rob_entry}, m_pay);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    rollback_config = 1; tick(); idle();
    disp(4'd1, 1, 4'd3, 32'd0, 0, 0, 32'd0, 32'd0); tick();
    disp(4'd2, 0, 0, 32'h22, 0, 0, 32'd0, 32'd0); tick(); idle();
    #2 rst = 0;
    model_reset();
    #1;
    n_checks++;
    if ({out_config, out_full, out_a, out_rob_entry} !== '0) begin
      n_errors++; $display("FAIL async_rst: cfg=%0b full=%0b a=%h rob=%0d want 0",
                           out_config, out_full, out_a, out_rob_entry);
    end
    @(negedge clk); rst = 1;
    alu_config = 1; alu_rob_entry = 4'd3; alu_val = 32'h5;
    tick(); idle(); tick();
    n_checks++;
    if (out_config !== 1'b0) begin
      n_errors++; $display("FAIL async_rst_cleared: out_config=%0b want 0", out_config);
    end
  endtask

  initial begin
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_bypass();
    test_full();
    test_priority();
    test_rollback_freeze();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
